// File: rtl/sysu_seg_scan_ctrl.sv
// Multiplexed scan controller driving one shared BCD-to-seven-segment decoder.
// Optional leading-zero suppression is compiled in with `define SEG_SCAN_LZS_EN.
//
// state    | meaning
// ST_GAP   | all digits dark, BCD pre-settled for the coming digit
// ST_SHOW  | digit idx lit for DWELL cycles
module sysu_seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000,
    parameter int GAP    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  lt_req,
    output logic                  BCD_A,
    output logic                  BCD_B,
    output logic                  BCD_C,
    output logic                  BCD_D,
    output logic                  LT_n,
    output logic                  RBI_n,
    output logic                  BI_n,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(DIGITS);

    localparam logic [CW-1:0] GAP_TC   = CW'(GAP - 1);
    localparam logic [CW-1:0] DWELL_TC = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_MSD  = IW'(DIGITS - 1);

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic                  pending_q, pending_d;

    logic [DIGITS-1:0]     dig_en_q, dig_en_d;
    logic                  bi_n_q, bi_n_d;
    logic [3:0]            bcd_q, bcd_d;
    logic                  lt_n_q;
    logic                  frame_done_q, frame_done_d;
    logic                  boundary;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        boundary  = 1'b0;

        if (ld) begin
            shadow_d  = din;
            pending_d = 1'b1;
        end

        if (!en) begin
            state_d = ST_GAP;
            idx_d   = IDX_MSD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_GAP: begin
                    if (cnt_q == GAP_TC) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_TC) begin
                        state_d  = ST_GAP;
                        cnt_d    = '0;
                        idx_d    = (idx_q == '0) ? IDX_MSD : idx_q - IW'(1);
                        boundary = (idx_q == '0);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            endcase
        end

        // A load landing on the boundary keeps its own pending flag for next frame.
        if (boundary && pending_q) begin
            active_d = shadow_q;
            if (!ld) begin
                pending_d = 1'b0;
            end
        end
    end

    always_comb begin
        dig_en_d     = '0;
        bcd_d        = 4'd0;
        bi_n_d       = (state_d == ST_SHOW);
        frame_done_d = boundary;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                bcd_d       = active_d[i*4 +: 4];
                dig_en_d[i] = (state_d == ST_SHOW);
            end
        end
    end

`ifdef SEG_SCAN_LZS_EN
    logic [DIGITS-1:0] lz;
    logic              zero_run;
    logic              rbi_n_q, rbi_n_d;

    // Suppression runs from the MSD down and stops at the first nonzero nibble.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (active_d[i*4 +: 4] == 4'd0);
            lz[i]    = zero_run && (i != 0);
        end
        rbi_n_d = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((idx_d == IW'(i)) && (state_d == ST_SHOW)) begin
                rbi_n_d = ~lz[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbi_n_q <= 1'b1;
        end else begin
            rbi_n_q <= rbi_n_d;
        end
    end

    assign RBI_n = rbi_n_q;
`else
    assign RBI_n = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_GAP;
            idx_q        <= IDX_MSD;
            cnt_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            dig_en_q     <= '0;
            bi_n_q       <= 1'b0;
            bcd_q        <= 4'd0;
            lt_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            dig_en_q     <= dig_en_d;
            bi_n_q       <= bi_n_d;
            bcd_q        <= bcd_d;
            lt_n_q       <= ~lt_req;
            frame_done_q <= frame_done_d;
        end
    end

    assign BCD_A      = bcd_q[0];
    assign BCD_B      = bcd_q[1];
    assign BCD_C      = bcd_q[2];
    assign BCD_D      = bcd_q[3];
    assign LT_n       = lt_n_q;
    assign BI_n       = bi_n_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sysu_seg_scan_ctrl.sv
// Bench for sysu_seg_scan_ctrl: directed scenarios plus random traffic against
// a time-based reference model (position within the frame derived arithmetically).
module tb_sysu_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DWELL  = 4;
    localparam int GAP    = 1;
    localparam int SLOT   = GAP + DWELL;
    localparam int FRAME  = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst, en, ld, lt_req;
    logic [15:0] din;
    logic        BCD_A, BCD_B, BCD_C, BCD_D, LT_n, RBI_n, BI_n, frame_done;
    logic [3:0]  dig_en;

    sysu_seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ld         (ld),
        .din        (din),
        .lt_req     (lt_req),
        .BCD_A      (BCD_A),
        .BCD_B      (BCD_B),
        .BCD_C      (BCD_C),
        .BCD_D      (BCD_D),
        .LT_n       (LT_n),
        .RBI_n      (RBI_n),
        .BI_n       (BI_n),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: m_t counts cycles since the scan was (re)started.
    int          m_t    = 0;
    logic [15:0] m_act  = '0;
    logic [15:0] m_sh   = '0;
    bit          m_pend = 0;
    bit          m_ltn  = 1;
    bit          m_fd   = 0;

    task automatic model_edge();
        if (rst) begin
            m_t = 0; m_act = '0; m_sh = '0; m_pend = 0; m_ltn = 1; m_fd = 0;
        end else begin
            m_fd = en && ((m_t % FRAME) == FRAME - 1);
            if (m_fd && m_pend) begin
                m_act  = m_sh;
                m_pend = 0;
            end
            if (ld) begin
                m_sh   = din;
                m_pend = 1;
            end
            m_t   = en ? m_t + 1 : 0;
            m_ltn = !lt_req;
        end
    endtask

    task automatic check_all();
        int          p, d;
        bit          show, lz, exp_rbi;
        logic [3:0]  exp_dig, nib;
        p       = m_t % FRAME;
        d       = DIGITS - 1 - p / SLOT;
        show    = (p % SLOT) >= GAP;
        exp_dig = show ? 4'(1 << d) : 4'd0;
        nib     = 4'((m_act >> (4 * d)) & 16'h000F);
        lz      = (d != 0) && ((m_act >> (4 * d)) == 16'd0);
`ifdef SEG_SCAN_LZS_EN
        exp_rbi = show ? !lz : 1'b1;
`else
        exp_rbi = 1'b1;
`endif
        chk("dig_en",     32'(dig_en), 32'(exp_dig));
        chk("BI_n",       32'(BI_n), 32'(show));
        chk("BCD",        32'({BCD_D, BCD_C, BCD_B, BCD_A}), 32'(nib));
        chk("LT_n",       32'(LT_n), 32'(m_ltn));
        chk("RBI_n",      32'(RBI_n), 32'(exp_rbi));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("onehot",     32'($countones(dig_en) <= 1), 32'd1);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_phase(input int ph, input string tag);
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != ph; k++) cyc();
        chk(tag, 32'(m_t % FRAME), 32'(ph));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ld = 1'b0; din = '0; lt_req = 1'b0;
        run(2);
        rst = 1'b0;
        cyc();
        chk("first_show_msd", 32'(dig_en), 32'h8);
        run(44);

        // Load 0305 just after a frame start; applies at the following boundary.
        wait_phase(2, "sync_ld0305");
        ld = 1'b1; din = 16'h0305;
        cyc();
        ld = 1'b0;
        run(2 * FRAME);

        // 9999 pending, then 1234 loaded exactly on the boundary.
        ld = 1'b1; din = 16'h9999;
        cyc();
        ld = 1'b0;
        cyc();
        wait_phase(FRAME - 1, "sync_boundary");
        ld = 1'b1; din = 16'h1234;
        cyc();
        ld = 1'b0;
        chk("bnd_active_9999", 32'({BCD_D, BCD_C, BCD_B, BCD_A}), 32'h9);
        run(2 * FRAME);

        // Lamp test mid-frame.
        lt_req = 1'b1;
        cyc();
        chk("lt_latency", 32'(LT_n), 32'd0);
        run(12);
        lt_req = 1'b0;
        run(3);

        // Enable drop while digit 2 is lit, then restart from the MSD.
        wait_phase(7, "sync_d2");
        chk("d2_lit", 32'(dig_en), 32'h4);
        en = 1'b0;
        cyc();
        chk("en_off_dark", 32'(dig_en), 32'h0);
        run(3);
        en = 1'b1;
        cyc();
        cyc();
        chk("restart_msd", 32'(dig_en), 32'h8);
        run(FRAME);

        // Reset mid-SHOW with a pending load that must be discarded.
        wait_phase(1, "sync_rst");
        ld = 1'b1; din = 16'h4321;
        cyc();
        ld = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        run(2 * FRAME + 5);

        // Random traffic including nibbles above 9 and sparse resets.
        for (int n = 0; n < 2500; n++) begin
            en     = ($urandom % 50) != 0;
            ld     = ($urandom % 12) == 0;
            lt_req = ($urandom % 8) == 0;
            rst    = ($urandom % 400) == 0;
            case ($urandom % 4)
                0:       din = 16'($urandom);
                1:       din = 16'($urandom % 10);
                2:       din = 16'($urandom % 256);
                default: din = 16'h0000;
            endcase
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
